// File: rtl/spi_slave.sv
// SPI responder (CPHA=0, configurable CPOL) with oversampled SCLK/CS/MOSI and a single-entry transmit buffer.
// Optional macro SPI_SLAVE_LSB_FIRST_EN switches both directions to LSB-first.
module spi_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        CPOL       = 1'b0
) (
    input  logic                  clk,
    input  logic                  real_reset,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int unsigned OUT_BIT = 0;
`else
    localparam int unsigned OUT_BIT = DATA_WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RELOAD = 2'd2
    } state_e;

    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic tx_ready_q, tx_ready_d;
    logic miso_q, miso_d;
    logic miso_oe_q, miso_oe_d;
    logic rx_valid_q, rx_valid_d;
    logic done_q, done_d;
    logic tx_underrun_q, tx_underrun_d;
    logic frame_abort_q, frame_abort_d;
    logic busy_q, busy_d;

    logic                  sclk_lead, sclk_trail, cs_fall, cs_rise, load;
    logic [DATA_WIDTH-1:0] rx_shift_nxt, tx_shift_nxt, next_word;

    // Input synchronizers; third stages give edge detection
    always_ff @(posedge clk or posedge real_reset) begin
        if (real_reset) begin
            sclk_s1_q <= CPOL;
            sclk_s2_q <= CPOL;
            sclk_s3_q <= CPOL;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= SCLK;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= CS;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sclk_lead  = (sclk_s2_q != sclk_s3_q) && (sclk_s2_q != CPOL);
    assign sclk_trail = (sclk_s2_q != sclk_s3_q) && (sclk_s2_q == CPOL);
    assign cs_fall    = ~cs_s2_q & cs_s3_q;
    assign cs_rise    = cs_s2_q & ~cs_s3_q;
    assign next_word  = tx_ready_q ? '0 : buf_q;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_shift_nxt = {mosi_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
    assign tx_shift_nxt = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
`else
    assign rx_shift_nxt = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};
    assign tx_shift_nxt = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
`endif

    // Next-state and output logic; CS rise takes priority over any SCLK edge
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        buf_d         = buf_q;
        rx_data_d     = rx_data_q;
        tx_ready_d    = tx_ready_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_valid_d    = 1'b0;
        done_d        = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;

        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b0;
                    state_d    = IDLE;
                end else if (sclk_lead) begin
                    rx_shift_d = rx_shift_nxt;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RELOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_trail && (bit_cnt_q != '0)) begin
                    tx_shift_d = tx_shift_nxt;
                    miso_d     = tx_shift_nxt[OUT_BIT];
                end
            end
            RELOAD: begin
                if (cs_rise) begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    state_d   = IDLE;
                end else if (sclk_trail) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            tx_shift_d    = next_word;
            miso_d        = next_word[OUT_BIT];
            tx_underrun_d = tx_ready_q;
            tx_ready_d    = 1'b1;
        end

        // A write into an empty buffer lands even when the same cycle underruns
        if (tx_valid && tx_ready_q) begin
            buf_d      = tx_data;
            tx_ready_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge real_reset) begin
        if (real_reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            buf_q         <= '0;
            rx_data_q     <= '0;
            tx_ready_q    <= 1'b1;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            buf_q         <= buf_d;
            rx_data_q     <= rx_data_d;
            tx_ready_q    <= tx_ready_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_valid_q    <= rx_valid_d;
            done_q        <= done_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            busy_q        <= busy_d;
        end
    end

    assign MISO        = miso_q;
    assign MISO_OE     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: CPOL=0 and CPOL=1 instances driven by a bit-level SPI initiator model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       real_reset;
    logic       sclk, sclk1;
    logic       cs0, cs1, mosi;
    logic       tx_valid0, tx_valid1;
    logic [7:0] tx_data;

    logic       miso0, oe0, tx_ready0, rx_valid0, und0_s, abt0_s, busy0;
    logic [7:0] rx_data0;
    logic       miso1, oe1, tx_ready1, rx_valid1, und1_s, abt1_s, busy1;
    logic [7:0] rx_data1;

    int errors = 0;
    int checks = 0;
    int rxv0 = 0, und0 = 0, abt0 = 0, rxv1 = 0;

    always #5 clk = ~clk;
    assign sclk1 = ~sclk;

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0)) u_dut0 (
        .clk(clk), .real_reset(real_reset), .SCLK(sclk), .CS(cs0), .MOSI(mosi),
        .MISO(miso0), .MISO_OE(oe0), .tx_data(tx_data), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .tx_underrun(und0_s), .frame_abort(abt0_s), .busy(busy0)
    );

    spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1)) u_dut1 (
        .clk(clk), .real_reset(real_reset), .SCLK(sclk1), .CS(cs1), .MOSI(mosi),
        .MISO(miso1), .MISO_OE(oe1), .tx_data(tx_data), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .tx_underrun(und1_s), .frame_abort(abt1_s), .busy(busy1)
    );

    // Strobe counters
    always @(negedge clk) begin
        if (rx_valid0) rxv0++;
        if (und0_s)    und0++;
        if (abt0_s)    abt0++;
        if (rx_valid1) rxv1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCLK period (16 clk): MISO sampled just before the leading edge
    task automatic do_bit(input logic sel, input logic b, output logic m);
        mosi = b;
        clocks(8);
        m = sel ? miso1 : miso0;
        sclk = 1'b1;
        clocks(8);
        sclk = 1'b0;
    endtask

    task automatic do_word(input logic sel, input logic [7:0] w, input int n, output logic [7:0] m);
        logic mb;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            do_bit(sel, w[7-i], mb);
            m = {m[6:0], mb};
        end
    endtask

    task automatic write_tx(input logic sel, input logic [7:0] d);
        tx_data = d;
        if (sel) tx_valid1 = 1'b1;
        else     tx_valid0 = 1'b1;
        clocks(1);
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] m, m1, m2;
        int base_r, base_u, base_a;

        real_reset = 1'b1;
        sclk = 1'b0; cs0 = 1'b1; cs1 = 1'b1; mosi = 1'b0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data = 8'h00;
        clocks(3);
        check("rst_miso", miso0, 0);
        check("rst_oe", oe0, 0);
        check("rst_tx_ready", tx_ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_rx_data", rx_data0, 0);
        check("rst_rx_valid", rx_valid0, 0);
        real_reset = 1'b0;
        clocks(3);

        // Single word: respond 0x3C while receiving 0xA5
        write_tx(1'b0, 8'h3C);
        check("t1_ready_full", tx_ready0, 0);
        cs0 = 1'b0;
        clocks(4);
        check("t1_ready_after_cs", tx_ready0, 1);
        check("t1_busy", busy0, 1);
        check("t1_oe", oe0, 1);
        base_r = rxv0;
        do_word(1'b0, 8'hA5, 8, m);
        check("t1_miso", m, 8'h3C);
        check("t1_rx_data", rx_data0, 8'hA5);
        check("t1_rx_valid_cnt", rxv0 - base_r, 1);
        clocks(8);
        cs0 = 1'b1;
        clocks(6);
        check("t1_busy_end", busy0, 0);
        check("t1_oe_end", oe0, 0);
        check("t1_miso_end", miso0, 0);

        // Back-to-back words with a refill during the first
        write_tx(1'b0, 8'h81);
        cs0 = 1'b0;
        clocks(4);
        write_tx(1'b0, 8'h7E);
        base_r = rxv0;
        base_u = und0;
        do_word(1'b0, 8'h12, 8, m1);
        check("t2_rx_data0", rx_data0, 8'h12);
        do_word(1'b0, 8'h34, 8, m2);
        check("t2_miso0", m1, 8'h81);
        check("t2_miso1", m2, 8'h7E);
        check("t2_rx_data1", rx_data0, 8'h34);
        check("t2_rx_valid_cnt", rxv0 - base_r, 2);
        check("t2_underrun_cnt", und0 - base_u, 0);
        clocks(8);
        cs0 = 1'b1;
        clocks(6);

        // Underrun: empty buffer at CS fall
        base_u = und0;
        cs0 = 1'b0;
        do_word(1'b0, 8'hFF, 8, m);
        check("t3_underrun_cnt", und0 - base_u, 1);
        check("t3_miso", m, 8'h00);
        check("t3_rx_data", rx_data0, 8'hFF);
        clocks(8);
        cs0 = 1'b1;
        clocks(6);

        // Abort after 5 of 8 bits
        base_a = abt0;
        base_r = rxv0;
        cs0 = 1'b0;
        do_word(1'b0, 8'h55, 5, m);
        clocks(8);
        cs0 = 1'b1;
        clocks(6);
        check("t4_abort_cnt", abt0 - base_a, 1);
        check("t4_rx_valid_cnt", rxv0 - base_r, 0);
        check("t4_rx_data", rx_data0, 8'hFF);
        check("t4_oe", oe0, 0);
        check("t4_busy", busy0, 0);

        // CPOL=1 instance: receive 0x5A, respond 0xC3
        write_tx(1'b1, 8'hC3);
        base_r = rxv1;
        cs1 = 1'b0;
        do_word(1'b1, 8'h5A, 8, m);
        check("t5_miso", m, 8'hC3);
        check("t5_rx_data", rx_data1, 8'h5A);
        check("t5_rx_valid_cnt", rxv1 - base_r, 1);
        clocks(8);
        cs1 = 1'b1;
        clocks(6);
        check("t5_oe_end", oe1, 0);

        // Reset mid-word with a full buffer and MISO high
        write_tx(1'b0, 8'hFF);
        cs0 = 1'b0;
        clocks(4);
        write_tx(1'b0, 8'h66);
        base_a = abt0;
        base_r = rxv0;
        do_word(1'b0, 8'hF0, 3, m);
        check("t6_pre_busy", busy0, 1);
        check("t6_pre_miso", miso0, 1);
        real_reset = 1'b1;
        #1;
        check("t6_miso", miso0, 0);
        check("t6_oe", oe0, 0);
        check("t6_busy", busy0, 0);
        check("t6_tx_ready", tx_ready0, 1);
        check("t6_rx_data", rx_data0, 0);
        check("t6_strobes", {rx_valid0, und0_s, abt0_s}, 3'b000);
        clocks(2);
        cs0 = 1'b1;
        clocks(3);
        real_reset = 1'b0;
        clocks(3);
        cs0 = 1'b0;
        do_word(1'b0, 8'h0F, 8, m);
        check("t6_rx_data_after", rx_data0, 8'h0F);
        check("t6_rx_valid_cnt", rxv0 - base_r, 1);
        check("t6_abort_cnt", abt0 - base_a, 0);
        clocks(8);
        cs0 = 1'b1;
        clocks(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
